y_dct_unit: RTL and testbench

- Forward 8x8 2-D DCT-II for the luma (Y) channel of the JPEG encoder.
- Accepts one 8-bit pixel per enabled clock in raster order (row-major, 64 pixels per block).
- Level-shifts each pixel by -128 and computes the orthonormal DCT.
- Presents all 64 signed 16-bit coefficients in parallel to the downstream quantizer, with a sticky valid flag.

---
 rtl/y_dct_pkg.sv | 55 +++++
 rtl/y_dct_row_mac.sv | 69 ++++++
 rtl/y_dct_unit.sv | 159 +++++++++++++++
 tb/tb_y_dct_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_dct_pkg.sv
// Shared types and DCT-II cosine table for the luma 8x8 DCT.
// Y_DCT_ROUND_EN selects round-half-up scaling of the final coefficients.
package y_dct_pkg;

  localparam int COEF_FRAC = 14;
  localparam int OUT_W     = 16;
  localparam int ZSH       = 2 * COEF_FRAC;

  typedef logic        [7:0]       pix_t;
  typedef logic signed [8:0]       samp_t;
  typedef logic signed [OUT_W-1:0] coef_t;
  typedef logic signed [31:0]      yacc_t;
  typedef logic signed [47:0]      zacc_t;

  localparam logic signed [15:0] C0 = 16'sd5793;
  localparam logic signed [15:0] C1 = 16'sd8035;
  localparam logic signed [15:0] C2 = 16'sd7568;
  localparam logic signed [15:0] C3 = 16'sd6811;
  localparam logic signed [15:0] C4 = 16'sd5793;
  localparam logic signed [15:0] C5 = 16'sd4551;
  localparam logic signed [15:0] C6 = 16'sd3135;
  localparam logic signed [15:0] C7 = 16'sd1598;

  // Magnitudes rounded once, signs applied after: AC rows sum to 0.
  localparam logic signed [15:0] DCT_T [8][8] = '{
    '{ C0,  C0,  C0,  C0,  C0,  C0,  C0,  C0},
    '{ C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1},
    '{ C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2},
    '{ C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3},
    '{ C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4},
    '{ C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5},
    '{ C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6},
    '{ C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7}
  };

`ifdef Y_DCT_ROUND_EN
  localparam zacc_t ZRND = zacc_t'(1) <<< (ZSH - 1);
`endif

  function automatic coef_t z_scale(input zacc_t a);
    zacc_t t;
`ifdef Y_DCT_ROUND_EN
    t = (a + ZRND) >>> ZSH;
`else
    t = a >>> ZSH;
`endif
    if (t > 48'sd32767) begin
      return 16'sh7fff;
    end else if (t < -48'sd32768) begin
      return 16'sh8000;
    end
    return t[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/y_dct_row_mac.sv
// Row pass of the 2-D DCT: eight MACs accumulate one pixel row
// into horizontal-frequency sums and hand the row to the column pass.
module y_dct_row_mac
  import y_dct_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] pix_i,
  input  logic [5:0] cnt_i,
  output yacc_t      yrow_o [8],
  output logic       row_vld_o,
  output logic [2:0] row_idx_o
);

  samp_t      s;
  yacc_t      sum    [8];
  yacc_t      yacc_q [8];
  yacc_t      yacc_d [8];
  yacc_t      yrow_q [8];
  yacc_t      yrow_d [8];
  logic       vld_q, vld_d;
  logic [2:0] idx_q, idx_d;

  always_comb begin
    s     = samp_t'({1'b0, pix_i}) - 9'sd128;
    vld_d = 1'b0;
    idx_d = idx_q;
    for (int v = 0; v < 8; v++) begin
      sum[v]    = yacc_q[v]
                + yacc_t'(s) * yacc_t'(DCT_T[v][cnt_i[2:0]]);
      yacc_d[v] = yacc_q[v];
      yrow_d[v] = yrow_q[v];
      if (en_i) begin
        if (cnt_i[2:0] == 3'd7) begin
          yrow_d[v] = sum[v];
          yacc_d[v] = '0;
        end else begin
          yacc_d[v] = sum[v];
        end
      end
    end
    if (en_i && cnt_i[2:0] == 3'd7) begin
      vld_d = 1'b1;
      idx_d = cnt_i[5:3];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      idx_q <= '0;
      for (int v = 0; v < 8; v++) begin
        yacc_q[v] <= '0;
        yrow_q[v] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      yacc_q <= yacc_d;
      yrow_q <= yrow_d;
    end
  end

  assign yrow_o    = yrow_q;
  assign row_vld_o = vld_q;
  assign row_idx_o = idx_q;

endmodule

// File: rtl/y_dct_unit.sv
// Forward 8x8 DCT-II for JPEG luma: row MACs, column accumulate, scale.
// Y_DCT_ROUND_EN enables round-half-up in the final scaling.
module y_dct_unit
  import y_dct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [7:0]        data_in,
  output logic              output_enable,
  output logic signed [15:0] Z11_final, Z12_final, Z13_final, Z14_final,
  output logic signed [15:0] Z15_final, Z16_final, Z17_final, Z18_final,
  output logic signed [15:0] Z21_final, Z22_final, Z23_final, Z24_final,
  output logic signed [15:0] Z25_final, Z26_final, Z27_final, Z28_final,
  output logic signed [15:0] Z31_final, Z32_final, Z33_final, Z34_final,
  output logic signed [15:0] Z35_final, Z36_final, Z37_final, Z38_final,
  output logic signed [15:0] Z41_final, Z42_final, Z43_final, Z44_final,
  output logic signed [15:0] Z45_final, Z46_final, Z47_final, Z48_final,
  output logic signed [15:0] Z51_final, Z52_final, Z53_final, Z54_final,
  output logic signed [15:0] Z55_final, Z56_final, Z57_final, Z58_final,
  output logic signed [15:0] Z61_final, Z62_final, Z63_final, Z64_final,
  output logic signed [15:0] Z65_final, Z66_final, Z67_final, Z68_final,
  output logic signed [15:0] Z71_final, Z72_final, Z73_final, Z74_final,
  output logic signed [15:0] Z75_final, Z76_final, Z77_final, Z78_final,
  output logic signed [15:0] Z81_final, Z82_final, Z83_final, Z84_final,
  output logic signed [15:0] Z85_final, Z86_final, Z87_final, Z88_final
);

  logic [5:0] cnt_q, cnt_d;
  yacc_t      yrow [8];
  logic       row_vld;
  logic [2:0] row_idx;
  zacc_t      zacc_q [8][8];
  zacc_t      zacc_d [8][8];
  coef_t      zf_q   [8][8];
  coef_t      zf_d   [8][8];
  logic       zdone_q, zdone_d;
  logic       oe_q, oe_d;

  assign cnt_d = enable ? cnt_q + 6'd1 : cnt_q;

  y_dct_row_mac u_row (
    .clk_i     (clk),
    .rst_ni    (rst),
    .en_i      (enable),
    .pix_i     (data_in),
    .cnt_i     (cnt_q),
    .yrow_o    (yrow),
    .row_vld_o (row_vld),
    .row_idx_o (row_idx)
  );

  // Column pass runs free of enable so a block flushes after input stops.
  always_comb begin
    zdone_d = row_vld && (row_idx == 3'd7);
    oe_d    = oe_q | zdone_q;
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        zacc_d[u][v] = zacc_q[u][v];
        zf_d[u][v]   = zf_q[u][v];
        if (row_vld) begin
          zacc_d[u][v] = ((row_idx == 3'd0) ? '0 : zacc_q[u][v])
                       + 48'(DCT_T[u][row_idx]) * 48'(yrow[v]);
        end
        if (zdone_q) begin
          zf_d[u][v] = z_scale(zacc_q[u][v]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      zdone_q <= 1'b0;
      oe_q    <= 1'b0;
      for (int u = 0; u < 8; u++) begin
        for (int v = 0; v < 8; v++) begin
          zacc_q[u][v] <= '0;
          zf_q[u][v]   <= '0;
        end
      end
    end else begin
      cnt_q   <= cnt_d;
      zdone_q <= zdone_d;
      oe_q    <= oe_d;
      zacc_q  <= zacc_d;
      zf_q    <= zf_d;
    end
  end

  assign output_enable = oe_q;

  assign Z11_final = zf_q[0][0];
  assign Z12_final = zf_q[0][1];
  assign Z13_final = zf_q[0][2];
  assign Z14_final = zf_q[0][3];
  assign Z15_final = zf_q[0][4];
  assign Z16_final = zf_q[0][5];
  assign Z17_final = zf_q[0][6];
  assign Z18_final = zf_q[0][7];
  assign Z21_final = zf_q[1][0];
  assign Z22_final = zf_q[1][1];
  assign Z23_final = zf_q[1][2];
  assign Z24_final = zf_q[1][3];
  assign Z25_final = zf_q[1][4];
  assign Z26_final = zf_q[1][5];
  assign Z27_final = zf_q[1][6];
  assign Z28_final = zf_q[1][7];
  assign Z31_final = zf_q[2][0];
  assign Z32_final = zf_q[2][1];
  assign Z33_final = zf_q[2][2];
  assign Z34_final = zf_q[2][3];
  assign Z35_final = zf_q[2][4];
  assign Z36_final = zf_q[2][5];
  assign Z37_final = zf_q[2][6];
  assign Z38_final = zf_q[2][7];
  assign Z41_final = zf_q[3][0];
  assign Z42_final = zf_q[3][1];
  assign Z43_final = zf_q[3][2];
  assign Z44_final = zf_q[3][3];
  assign Z45_final = zf_q[3][4];
  assign Z46_final = zf_q[3][5];
  assign Z47_final = zf_q[3][6];
  assign Z48_final = zf_q[3][7];
  assign Z51_final = zf_q[4][0];
  assign Z52_final = zf_q[4][1];
  assign Z53_final = zf_q[4][2];
  assign Z54_final = zf_q[4][3];
  assign Z55_final = zf_q[4][4];
  assign Z56_final = zf_q[4][5];
  assign Z57_final = zf_q[4][6];
  assign Z58_final = zf_q[4][7];
  assign Z61_final = zf_q[5][0];
  assign Z62_final = zf_q[5][1];
  assign Z63_final = zf_q[5][2];
  assign Z64_final = zf_q[5][3];
  assign Z65_final = zf_q[5][4];
  assign Z66_final = zf_q[5][5];
  assign Z67_final = zf_q[5][6];
  assign Z68_final = zf_q[5][7];
  assign Z71_final = zf_q[6][0];
  assign Z72_final = zf_q[6][1];
  assign Z73_final = zf_q[6][2];
  assign Z74_final = zf_q[6][3];
  assign Z75_final = zf_q[6][4];
  assign Z76_final = zf_q[6][5];
  assign Z77_final = zf_q[6][6];
  assign Z78_final = zf_q[6][7];
  assign Z81_final = zf_q[7][0];
  assign Z82_final = zf_q[7][1];
  assign Z83_final = zf_q[7][2];
  assign Z84_final = zf_q[7][3];
  assign Z85_final = zf_q[7][4];
  assign Z86_final = zf_q[7][5];
  assign Z87_final = zf_q[7][6];
  assign Z88_final = zf_q[7][7];

endmodule

// File: tb/tb_y_dct_unit.sv
// Bench for y_dct_unit: block table, real-valued reference DCT,
// cycle-due scoreboard, pause and mid-block reset sequences.
module tb_y_dct_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       oe;
  wire signed [15:0] zo [8][8];

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  localparam int NOCHK = 99999;
`ifdef Y_DCT_ROUND_EN
  localparam int TOL = 1;
  localparam int RND = 1;
`else
  localparam int TOL = 2;
  localparam int RND = 0;
`endif

  typedef struct {
    int pat;
    int fill;
    int dc_r;
    int dc_f;
    int z88;
    int zmode;
  } vec_t;

  vec_t vec [5];
  int   pix     [16][64];
  real  ref_c   [16][64];
  int   exp_dc  [16];
  int   exp_z88 [16];
  int   zmode   [16];
  int   due_q [$];
  int   id_q  [$];
  int   rise_due = -1;
  int   nblk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  y_dct_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .output_enable(oe),
    .Z11_final(zo[0][0]), .Z12_final(zo[0][1]), .Z13_final(zo[0][2]), .Z14_final(zo[0][3]),
    .Z15_final(zo[0][4]), .Z16_final(zo[0][5]), .Z17_final(zo[0][6]), .Z18_final(zo[0][7]),
    .Z21_final(zo[1][0]), .Z22_final(zo[1][1]), .Z23_final(zo[1][2]), .Z24_final(zo[1][3]),
    .Z25_final(zo[1][4]), .Z26_final(zo[1][5]), .Z27_final(zo[1][6]), .Z28_final(zo[1][7]),
    .Z31_final(zo[2][0]), .Z32_final(zo[2][1]), .Z33_final(zo[2][2]), .Z34_final(zo[2][3]),
    .Z35_final(zo[2][4]), .Z36_final(zo[2][5]), .Z37_final(zo[2][6]), .Z38_final(zo[2][7]),
    .Z41_final(zo[3][0]), .Z42_final(zo[3][1]), .Z43_final(zo[3][2]), .Z44_final(zo[3][3]),
    .Z45_final(zo[3][4]), .Z46_final(zo[3][5]), .Z47_final(zo[3][6]), .Z48_final(zo[3][7]),
    .Z51_final(zo[4][0]), .Z52_final(zo[4][1]), .Z53_final(zo[4][2]), .Z54_final(zo[4][3]),
    .Z55_final(zo[4][4]), .Z56_final(zo[4][5]), .Z57_final(zo[4][6]), .Z58_final(zo[4][7]),
    .Z61_final(zo[5][0]), .Z62_final(zo[5][1]), .Z63_final(zo[5][2]), .Z64_final(zo[5][3]),
    .Z65_final(zo[5][4]), .Z66_final(zo[5][5]), .Z67_final(zo[5][6]), .Z68_final(zo[5][7]),
    .Z71_final(zo[6][0]), .Z72_final(zo[6][1]), .Z73_final(zo[6][2]), .Z74_final(zo[6][3]),
    .Z75_final(zo[6][4]), .Z76_final(zo[6][5]), .Z77_final(zo[6][6]), .Z78_final(zo[6][7]),
    .Z81_final(zo[7][0]), .Z82_final(zo[7][1]), .Z83_final(zo[7][2]), .Z84_final(zo[7][3]),
    .Z85_final(zo[7][4]), .Z86_final(zo[7][5]), .Z87_final(zo[7][6]), .Z88_final(zo[7][7])
  );

  task automatic chk(input string nm, input int got, input int exp_v);
    n_run++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
    end
  endtask

  task automatic chk_tol(input string nm, input int got, input int exp_v, input int tol);
    n_run++;
    if (got > exp_v + tol || got < exp_v - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, got, exp_v, tol);
    end
  endtask

  function automatic real acoef(input int k, input int n);
    real ck;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    return ck / 2.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
  endfunction

  task automatic make_block(input int id, input int pat, input int fill);
    real acc;
    for (int i = 0; i < 64; i++) begin
      case (pat)
        0: pix[id][i] = fill;
        1: pix[id][i] = ((i & 1) ^ ((i >> 3) & 1)) != 0 ? 255 : 0;
        2: pix[id][i] = int'($urandom_range(0, 255));
        default: pix[id][i] = int'($urandom_range(150, 255));
      endcase
    end
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        acc = 0.0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            acc += acoef(u, r) * acoef(v, c) * real'(pix[id][r * 8 + c] - 128);
        ref_c[id][u * 8 + v] = acc;
      end
    end
  endtask

  task automatic feed(input int id, input int pause_at, input int pause_len);
    for (int i = 0; i < 64; i++) begin
      if (i == pause_at) begin
        for (int p = 0; p < pause_len; p++) begin
          @(negedge clk);
          enable = 1'b0;
        end
      end
      @(negedge clk);
      enable  = 1'b1;
      data_in = 8'(pix[id][i]);
      if (i == 63) begin
        due_q.push_back(cyc + 3);
        id_q.push_back(id);
      end
    end
  endtask

  task automatic check_block(input int id);
    int  bad;
    int  nz;
    int  bu;
    int  bv;
    real d;
    chk($sformatf("oe_blk%0d", id), int'(oe), 1);
    bad = 0;
    bu = 0;
    bv = 0;
    nz = 0;
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        d = real'(int'(zo[u][v])) - ref_c[id][u * 8 + v];
        if (d < 0.0) d = -d;
        if (d > real'(TOL)) begin
          if (bad == 0) begin
            bu = u;
            bv = v;
          end
          bad++;
        end
        if ((zmode[id] == 1 && (u != 0 || v != 0)) ||
            (zmode[id] == 2 && ((u == 0) != (v == 0))))
          if (zo[u][v] != 16'sd0) nz++;
      end
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ref_blk%0d: %0d coefs off, Z%0d%0d got %0d required %f", id, bad,
               bu + 1, bv + 1, int'(zo[bu][bv]), ref_c[id][bu * 8 + bv]);
    end
    if (zmode[id] != 0) chk($sformatf("zeros_blk%0d", id), nz, 0);
    if (exp_dc[id] != NOCHK) chk($sformatf("dc_blk%0d", id), int'(zo[0][0]), exp_dc[id]);
    if (exp_z88[id] != NOCHK)
      chk_tol($sformatf("z88_blk%0d", id), int'(zo[7][7]), exp_z88[id], TOL);
  endtask

  always @(negedge clk) begin
    if (rise_due >= 0 && cyc == rise_due - 1) begin
      chk("oe_early", int'(oe), 0);
      rise_due = -1;
    end
    if (due_q.size() > 0 && cyc == due_q[0]) begin
      void'(due_q.pop_front());
      check_block(id_q.pop_front());
    end
  end

  task automatic drain();
    for (int k = 0; k < 50 && due_q.size() > 0; k++) @(negedge clk);
    chk("drain_pending", due_q.size(), 0);
  endtask

  task automatic all_zero(input string nm);
    int nz;
    nz = 0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        if (zo[u][v] != 16'sd0) nz++;
    chk(nm, nz, 0);
  endtask

  task automatic setup(input int id, input vec_t t);
    make_block(id, t.pat, t.fill);
    exp_dc[id]  = (RND != 0) ? t.dc_r : t.dc_f;
    exp_z88[id] = t.z88;
    zmode[id]   = t.zmode;
  endtask

  initial begin
    int   id;
    vec_t rnd_hi;
    vec[0] = '{0, 128, 0, 0, NOCHK, 1};
    vec[1] = '{0, 0, -1024, -1025, NOCHK, 1};
    vec[2] = '{0, 255, 1016, 1016, NOCHK, 1};
    vec[3] = '{1, 0, -4, -5, -838, 2};
    vec[4] = '{2, 0, NOCHK, NOCHK, NOCHK, 0};
    rnd_hi = '{3, 0, NOCHK, NOCHK, NOCHK, 0};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_oe", int'(oe), 0);
    all_zero("reset_z");
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      id = nblk++;
      setup(id, vec[i]);
      feed(id, -1, 0);
      if (i == 0) rise_due = due_q[due_q.size() - 1];
    end

    id = nblk++;
    setup(id, rnd_hi);
    feed(id, 20, 5);
    @(negedge clk);
    enable = 1'b0;
    drain();
    chk_tol("dc_nonzero_before_rst", int'(zo[0][0]) > 100 ? 1 : 0, 1, 0);

    id = nblk++;
    make_block(id, 2, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      enable  = 1'b1;
      data_in = 8'(pix[id][i]);
    end
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b0;
    #1;
    chk("midrst_oe", int'(oe), 0);
    all_zero("midrst_z");
    @(negedge clk);
    rst = 1'b1;

    id = nblk++;
    setup(id, vec[3]);
    feed(id, -1, 0);
    rise_due = due_q[due_q.size() - 1];
    @(negedge clk);
    enable = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("oe_sticky", int'(oe), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
